// File: rtl/icache_refill.sv
// icache_refill: instruction-cache miss handler. Invalidates the victim line,
// issues one line-aligned burst read, writes each returned word into the data
// array, forwards the missed word to fetch, then rewrites the tag as valid.
module icache_refill #(
   parameter int ADDR_W     = 32,
   parameter int LINE_WORDS = 16,
   parameter int LINES      = 1024,
   localparam int WOFF_W    = $clog2(LINE_WORDS),
   localparam int IDX_W     = $clog2(LINES),
   localparam int TAG_W     = ADDR_W - IDX_W - WOFF_W - 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              miss_valid,
   input  logic [ADDR_W-1:0] miss_addr,
   output logic              miss_ready,
   output logic              mem_req_valid,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_req_ready,
   input  logic              mem_resp_valid,
   input  logic [ADDR_W-1:0] mem_resp_data,
   input  logic              mem_resp_last,
   output logic              data_we,
   output logic [IDX_W-1:0]  data_idx,
   output logic [WOFF_W-1:0] data_woff,
   output logic [ADDR_W-1:0] data_wdata,
   output logic              tag_we,
   output logic [IDX_W-1:0]  tag_idx,
   output logic [TAG_W-1:0]  tag_wtag,
   output logic              tag_wvalid,
   output logic              fwd_valid,
   output logic [ADDR_W-1:0] fwd_data,
   output logic              refill_done,
   output logic              refill_err
);

   typedef enum logic [2:0] {S_IDLE, S_INVAL, S_REQ, S_FILL, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [TAG_W-1:0]  tag_q;
   logic [IDX_W-1:0]  idx_q;
   logic [WOFF_W-1:0] woff_q;
   logic [WOFF_W-1:0] beat_q;
   logic              beat_acc;
   logic              beat_last;

   // byte-within-word bits never matter for an instruction line fill
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^miss_addr[1:0];

   assign beat_acc  = (state_q == S_FILL) && mem_resp_valid;
   assign beat_last = (beat_q == WOFF_W'(LINE_WORDS - 1));

   // state register
   always_ff @(posedge clock) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // miss latch and beat counter; counter wraps naturally at LINE_WORDS
   always_ff @(posedge clock) begin
      if (reset) begin
         tag_q  <= '0;
         idx_q  <= '0;
         woff_q <= '0;
         beat_q <= '0;
      end else if (state_q == S_IDLE && miss_valid) begin
         tag_q  <= miss_addr[ADDR_W-1 -: TAG_W];
         idx_q  <= miss_addr[WOFF_W+2 +: IDX_W];
         woff_q <= miss_addr[2 +: WOFF_W];
         beat_q <= '0;
      end else if (beat_acc) begin
         beat_q <= beat_q + WOFF_W'(1);
      end
   end

   // next state; fill length is set by the beat counter, not by mem_resp_last
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (miss_valid) state_d = S_INVAL;
         S_INVAL: state_d = S_REQ;
         S_REQ:   if (mem_req_ready) state_d = S_FILL;
         S_FILL:  if (beat_acc && beat_last) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // outputs; strobes are qualified by state, buses always carry the latched miss
   always_comb begin
      miss_ready    = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_addr  = {tag_q, idx_q, {(WOFF_W+2){1'b0}}};
      data_we       = 1'b0;
      data_idx      = idx_q;
      data_woff     = beat_q;
      data_wdata    = mem_resp_data;
      tag_we        = 1'b0;
      tag_idx       = idx_q;
      tag_wtag      = tag_q;
      tag_wvalid    = 1'b0;
      fwd_valid     = 1'b0;
      fwd_data      = mem_resp_data;
      refill_done   = 1'b0;
      refill_err    = 1'b0;
      case (state_q)
         S_IDLE:  miss_ready = 1'b1;
         S_INVAL: tag_we = 1'b1;
         S_REQ:   mem_req_valid = 1'b1;
         S_FILL: begin
            data_we    = beat_acc;
            fwd_valid  = beat_acc && (beat_q == woff_q);
            refill_err = beat_acc && (mem_resp_last != beat_last);
         end
         S_DONE: begin
            tag_we      = 1'b1;
            tag_wvalid  = 1'b1;
            refill_done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: directed refill scenarios checked every cycle against a
// transaction-level model, plus literal expectations per scenario.
module tb_icache_refill;
   logic        clock = 1'b0;
   logic        reset;
   logic        miss_valid;
   logic [31:0] miss_addr;
   logic        miss_ready;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        mem_resp_last;
   logic        data_we;
   logic [9:0]  data_idx;
   logic [3:0]  data_woff;
   logic [31:0] data_wdata;
   logic        tag_we;
   logic [9:0]  tag_idx;
   logic [15:0] tag_wtag;
   logic        tag_wvalid;
   logic        fwd_valid;
   logic [31:0] fwd_data;
   logic        refill_done;
   logic        refill_err;

   icache_refill dut (
      .clock(clock), .reset(reset),
      .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_last(mem_resp_last),
      .data_we(data_we), .data_idx(data_idx), .data_woff(data_woff), .data_wdata(data_wdata),
      .tag_we(tag_we), .tag_idx(tag_idx), .tag_wtag(tag_wtag), .tag_wvalid(tag_wvalid),
      .fwd_valid(fwd_valid), .fwd_data(fwd_data),
      .refill_done(refill_done), .refill_err(refill_err)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_chk++;
      n_err++;
      $display("FAIL %s: timed out (cycle %0d)", name, cyc);
   endtask

   // model: what has happened to the current miss so far
   bit          seen_rst = 0;
   bit          m_busy = 0, m_inval = 0, m_req = 0, m_fill = 0, m_done = 0;
   logic [31:0] m_addr = '0;
   int          m_beats = 0;
   bit          e_fill, e_fwd;

   // observed statistics for per-scenario literal checks
   int          n_we, n_fwd, n_done, n_rerr, n_tagv, n_reqc;
   logic [31:0] fwd_d, req_a;
   int          fwd_w, err_w, acc_cyc, done_cyc;
   logic [9:0]  inval_idx, done_idx;
   logic [15:0] done_tag;

   task automatic clr_stats();
      n_we = 0; n_fwd = 0; n_done = 0; n_rerr = 0; n_tagv = 0; n_reqc = 0;
      fwd_d = '0; req_a = '0; fwd_w = -1; err_w = -1;
      inval_idx = '0; done_idx = '0; done_tag = '0;
   endtask

   // compare on the falling edge, then advance the model by what the next rising edge samples
   always @(negedge clock) begin
      cyc++;
      if (seen_rst) begin
         e_fill = m_fill && mem_resp_valid;
         e_fwd  = e_fill && (m_beats == int'((m_addr >> 2) % 16));
         chk("miss_ready", miss_ready, !m_busy);
         chk("mem_req_valid", mem_req_valid, m_req);
         if (m_req) chk("mem_req_addr", mem_req_addr, m_addr & ~32'h3f);
         chk("tag_we", tag_we, m_inval || m_done);
         if (m_inval || m_done) begin
            chk("tag_idx", tag_idx, (m_addr >> 6) % 1024);
            chk("tag_wtag", tag_wtag, m_addr >> 16);
            chk("tag_wvalid", tag_wvalid, m_done);
         end
         chk("refill_done", refill_done, m_done);
         chk("data_we", data_we, e_fill);
         if (e_fill) begin
            chk("data_idx", data_idx, (m_addr >> 6) % 1024);
            chk("data_woff", data_woff, m_beats);
            chk("data_wdata", data_wdata, mem_resp_data);
         end
         chk("fwd_valid", fwd_valid, e_fwd);
         if (e_fwd) chk("fwd_data", fwd_data, mem_resp_data);
         chk("refill_err", refill_err, e_fill && (mem_resp_last != (m_beats == 15)));
         if (m_done) done_cyc = cyc;
         if (data_we) n_we++;
         if (fwd_valid) begin n_fwd++; fwd_d = fwd_data; fwd_w = int'(data_woff); end
         if (refill_done) n_done++;
         if (refill_err) begin n_rerr++; err_w = int'(data_woff); end
         if (mem_req_valid) begin n_reqc++; req_a = mem_req_addr; end
         if (tag_we && !tag_wvalid) inval_idx = tag_idx;
         if (tag_we && tag_wvalid) begin n_tagv++; done_idx = tag_idx; done_tag = tag_wtag; end
      end
      if (reset) begin
         seen_rst = 1;
         m_busy = 0; m_inval = 0; m_req = 0; m_fill = 0; m_done = 0; m_beats = 0;
      end else if (!m_busy) begin
         if (miss_valid) begin
            m_busy = 1; m_inval = 1; m_addr = miss_addr; acc_cyc = cyc;
         end
      end else if (m_inval) begin
         m_inval = 0; m_req = 1;
      end else if (m_req) begin
         if (mem_req_ready) begin m_req = 0; m_fill = 1; m_beats = 0; end
      end else if (m_fill) begin
         if (mem_resp_valid) begin
            m_beats++;
            if (m_beats == 16) begin m_fill = 0; m_done = 1; end
         end
      end else if (m_done) begin
         m_done = 0; m_busy = 0;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // present a miss until accepted; optionally leave miss_valid asserted
   task automatic do_miss(input logic [31:0] a, input bit keep);
      bit ok = 0;
      miss_valid = 1'b1;
      miss_addr  = a;
      for (int i = 0; i < 50; i++) begin
         if (miss_ready) begin ok = 1; tick(); break; end
         tick();
      end
      if (!ok) timeout_fail("miss_accept");
      if (!keep) miss_valid = 1'b0;
   endtask

   // wait for the burst request, stall it for 'stall' cycles, then handshake
   task automatic wait_req(input int stall);
      bit ok = 0;
      for (int i = 0; i < 20; i++) begin
         if (mem_req_valid) begin ok = 1; break; end
         tick();
      end
      if (!ok) timeout_fail("mem_req_valid");
      for (int i = 0; i < stall; i++) tick();
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
   endtask

   // n beats from offset 0 with random gaps; last on beat 15 and on errbeat
   task automatic send_beats(input int n, input int gapmax, input int errbeat, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         int g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
         for (int k = 0; k < g; k++) tick();
         mem_resp_valid = 1'b1;
         mem_resp_data  = base + 32'(i);
         mem_resp_last  = (i == 15) || (i == errbeat);
         tick();
         mem_resp_valid = 1'b0;
         mem_resp_last  = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; miss_valid = 1'b0; miss_addr = '0; mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_last = 1'b0;
      clr_stats();
      tick(); tick();
      reset = 1'b0;
      chk("rst_miss_ready", miss_ready, 1'b1);
      chk("rst_strobes", {mem_req_valid, data_we, tag_we, fwd_valid, refill_done, refill_err}, 6'b0);

      // basic refill, zero wait
      clr_stats();
      do_miss(32'h1234_5678, 0);
      wait_req(0);
      send_beats(16, 0, -1, 32'hA0);
      tick(); tick();
      chk("t1_inval_idx", inval_idx, 10'h159);
      chk("t1_req_addr", req_a, 32'h1234_5640);
      chk("t1_n_we", n_we, 16);
      chk("t1_n_fwd", n_fwd, 1);
      chk("t1_fwd_woff", fwd_w, 14);
      chk("t1_fwd_data", fwd_d, 32'hAE);
      chk("t1_done_tag", done_tag, 16'h1234);
      chk("t1_n_done", n_done, 1);
      chk("t1_n_rerr", n_rerr, 0);

      // request stalled 5 cycles
      clr_stats();
      do_miss(32'h0000_1000, 0);
      wait_req(5);
      send_beats(16, 0, -1, 32'h100);
      tick(); tick();
      chk("t2_req_cycles", n_reqc, 6);
      chk("t2_req_addr", req_a, 32'h0000_1000);
      chk("t2_n_we", n_we, 16);

      // random response gaps
      clr_stats();
      do_miss(32'h0000_2004, 0);
      wait_req(1);
      send_beats(16, 3, -1, 32'h200);
      tick(); tick();
      chk("t3_n_we", n_we, 16);
      chk("t3_n_done", n_done, 1);
      chk("t3_n_rerr", n_rerr, 0);
      chk("t3_fwd_woff", fwd_w, 1);

      // early last on beat 7
      clr_stats();
      do_miss(32'h0000_3000, 0);
      wait_req(0);
      send_beats(16, 1, 7, 32'h300);
      tick(); tick();
      chk("t4_n_rerr", n_rerr, 1);
      chk("t4_err_woff", err_w, 7);
      chk("t4_n_we", n_we, 16);
      chk("t4_n_done", n_done, 1);

      // reset mid-fill, stray responses, then a clean refill
      do_miss(32'h1234_5678, 0);
      wait_req(0);
      send_beats(6, 0, -1, 32'hA0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      clr_stats();
      mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
      tick(); tick();
      do_miss(32'h0000_0040, 0);
      wait_req(1);
      mem_resp_valid = 1'b0;
      send_beats(16, 0, -1, 32'h400);
      tick(); tick();
      chk("t5_n_tagv", n_tagv, 1);
      chk("t5_done_tag", done_tag, 16'h0000);
      chk("t5_done_idx", done_idx, 10'h001);
      chk("t5_n_we", n_we, 16);

      // miss_valid held through a refill
      clr_stats();
      do_miss(32'h0000_5000, 1);
      wait_req(0);
      send_beats(16, 0, -1, 32'h500);
      begin
         bit ok = 0;
         for (int i = 0; i < 10; i++) begin
            if (miss_ready) begin ok = 1; tick(); break; end
            tick();
         end
         if (!ok) timeout_fail("t6_second_accept");
      end
      miss_valid = 1'b0;
      chk("t6_idle_gap", acc_cyc - done_cyc, 1);
      wait_req(0);
      send_beats(16, 0, -1, 32'h600);
      tick(); tick();
      chk("t6_n_done", n_done, 2);
      chk("t6_n_we", n_we, 32);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Miss handler and line-refill engine that sits directly downstream of the instruction-cache lookup.
- Accepts one miss at a time and issues a single line-aligned burst read to the memory port.
- Writes each returned word into the cache data array, then writes the tag with valid set.
- Forwards the critical (missed) word to fetch as soon as it arrives, and pulses done when the line is complete.

Parameters:
- ADDR_W, 32, address and data word width in bits.
- LINE_WORDS, 16, words per cache line (64-byte line); power of two, ≥2.
- LINES, 1024, number of direct-mapped lines; power of two.
- Derived (not overridable):
  - WOFF_W = log2(LINE_WORDS) = 4
  - IDX_W = log2(LINES) = 10
  - TAG_W = ADDR_W - IDX_W - WOFF_W - 2 = 16

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- miss_valid  in  1  lookup reports a miss.
- miss_addr  in  ADDR_W  byte address of the missing fetch.
- miss_ready  out  1  engine idle and able to accept a miss.
- mem_req_valid  out  1  burst read request.
- mem_req_addr  out  ADDR_W  line-aligned byte address (low WOFF_W+2 bits zero).
- mem_req_ready  in  1  memory accepts request.
- mem_resp_valid  in  1  one data word returned.
- mem_resp_data  in  ADDR_W  returned word.
- mem_resp_last  in  1  memory marks final beat.
- data_we  out  1  data-array word write strobe.
- data_idx  out  IDX_W  line index for data write.
- data_woff  out  WOFF_W  word offset for data write.
- data_wdata  out  ADDR_W  word written.
- tag_we  out  1  tag/overhead write strobe.
- tag_idx  out  IDX_W  line index for tag write.
- tag_wtag  out  TAG_W  tag written.
- tag_wvalid  out  1  valid bit written.
- fwd_valid  out  1  critical word forwarded this cycle.
- fwd_data  out  ADDR_W  critical word.
- refill_done  out  1  one-cycle pulse when line is valid.
- refill_err  out  1  one-cycle pulse on beat-count/last mismatch.

Behaviour:
- Address split of the latched miss_addr: tag = [31:16], idx = [15:6], woff = [5:2], [1:0] ignored.
- States:
  - IDLE: miss_ready=1. On miss_valid, latch tag/idx/woff, zero the beat counter, and go to INVAL.
  - INVAL: exactly one cycle. Drive tag_we=1, tag_idx=idx, tag_wtag=tag, tag_wvalid=0, which invalidates the line so no stale hit occurs mid-fill. Go to REQ.
  - REQ: mem_req_valid=1, mem_req_addr={tag,idx,WOFF_W+2 zeros}. Hold stable until mem_req_ready; on the handshake cycle go to FILL. No timeout.
  - FILL: on each mem_resp_valid, drive combinationally in the same cycle:
    - data_we=1, data_idx=idx, data_woff=beat counter, data_wdata=mem_resp_data.
    - If the beat counter equals the latched woff: fwd_valid=1, fwd_data=mem_resp_data.
    - Increment the counter, which wraps at LINE_WORDS.
    - Words return in ascending order from offset 0 (no critical-word-first reordering).
    - When the accepted beat has counter==LINE_WORDS-1, go to DONE.
    - mem_resp_last is checked on every beat. refill_err pulses in the beat's cycle if last=1 on a non-final beat, or last=0 on the final beat. The beat counter stays authoritative: the fill still completes after exactly LINE_WORDS beats.
  - DONE: exactly one cycle. Drive tag_we=1, tag_wtag=tag, tag_wvalid=1, refill_done=1. Go to IDLE; miss_ready returns the next cycle.
- Latency with zero memory wait:
  - miss accepted at cycle 0; INVAL at 1; REQ at 2.
  - First beat no earlier than cycle 3.
  - done one cycle after the last beat.
- Boundary conditions:
  - mem_resp_valid outside FILL: ignored, no writes.
  - miss_valid outside IDLE: ignored; the requester must hold it until miss_ready.
  - Back-to-back misses: a new miss is accepted only in IDLE, so at least one idle cycle follows refill_done.
- Reset at any time (including mid-FILL):
  - Next state IDLE, counter 0.
  - All outputs 0 except miss_ready=1.
  - The partially filled line stays invalid because INVAL already cleared it.
- All strobes (data_we, tag_we, fwd_valid, refill_done, refill_err, mem_req_valid) are 0 whenever not explicitly driven above. Data buses are don't-care when their strobe is 0.

Test Plan:
- Reset, then miss_addr=0x1234_5678, mem_req_ready=1, 16 consecutive beats data=0xA0+i with last on i=15:
  - INVAL writes idx=0x159 valid=0.
  - mem_req_addr=0x1234_5640.
  - data writes woff 0..15.
  - fwd_valid only on beat 14 with fwd_data=0xAE.
  - tag_we tag=0x1234 valid=1 with refill_done one cycle after beat 15.
- mem_req_ready low for 5 cycles → mem_req_valid/addr held stable; no data writes occur before the handshake.
- Responses with random 0–3 cycle gaps → exactly 16 data_we pulses in order; refill_done once; refill_err never.
- mem_resp_last=1 on beat 7 → refill_err pulses at beat 7; fill continues to 16 beats; refill_done still asserts.
- Assert reset after beat 5, then issue a new miss 0x0000_0040 → no tag write with valid=1 for the first line; the new refill runs cleanly; stray mem_resp_valid before the new REQ causes no writes.
- miss_valid held high through a refill → a second refill starts only after an IDLE cycle with miss_ready=1.
